// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and types for the fetch / decode pipeline
// Contents: PC width, NOP and HALT encodings, fetch FSM state type,
//           rs/rt field positions within an instruction word.
package pipeline_pkg;

  localparam int PC_W = 7;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - combinational load-use hazard detector
// Ports:
//   idex_mem_read  in   load sitting in ID/EX
//   idex_rt        in   destination register of that load
//   rs, rt         in   source fields of the instruction in IF/ID
//   valid_reg      in   IF/ID holds a real instruction
//   stall          out  IF/ID consumer must wait one cycle
module hazard_unit
  import pipeline_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       valid_reg,
  output logic       stall
);

  logic w_dest_nonzero;
  logic w_src_match;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_dest_nonzero = (idex_rt != 5'd0);
  assign w_src_match    = (idex_rt == rs) || (idex_rt == rt);
  assign stall          = idex_mem_read && w_dest_nonzero && valid_reg && w_src_match;

endmodule

// File: rtl/fetch_if_id.sv
// rtl/fetch_if_id.sv - instruction fetch stage with IF/ID register, branch flush and load-use stall
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imem_addr / imem_data    combinational instruction-memory read
//   branch_taken/_target     fetch redirect from the branch resolver
//   idex_mem_read, idex_rt   load currently in ID/EX
//   instr_reg, pc_next_reg,  IF/ID contents for decode
//   valid_reg, rs, rt
//   bubble                   ID/EX must load zeroed controls this cycle
//   halted                   fetch stopped on HALT_WORD
module fetch_if_id
  import pipeline_pkg::*;
#(
  parameter int          PC_W      = pipeline_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0] HALT_WORD = pipeline_pkg::HALT_WORD
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            idex_mem_read,
  input  logic [4:0]      idex_rt,
  output logic [31:0]     instr_reg,
  output logic [PC_W-1:0] pc_next_reg,
  output logic            valid_reg,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic            bubble,
  output logic            halted
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc_next;
  logic            r_valid;

  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [31:0]     w_instr_nxt;
  logic [PC_W-1:0] w_pc_next_nxt;
  logic            w_valid_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_stall;

  // Wraps modulo 2^PC_W with no overflow indication.
  assign w_pc_inc = r_pc + PC_W'(1);

  hazard_unit u_hazard (
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .rs            (rs),
    .rt            (rt),
    .valid_reg     (r_valid),
    .stall         (w_stall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_WORD;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_pc_next <= w_pc_next_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  // Priority: branch redirect, then load-use hold, then halt detect, then fetch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_pc_next_nxt = r_pc_next;
    w_valid_nxt   = r_valid;

    if (branch_taken) begin
      w_state_nxt   = ST_RUN;
      w_pc_nxt      = branch_target;
      w_instr_nxt   = NOP_WORD;
      w_pc_next_nxt = '0;
      w_valid_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_stall) begin
            // Everything holds so the dependent instruction is re-presented.
          end else if (imem_data == HALT_WORD) begin
            // The halt word itself is never passed to decode.
            w_state_nxt   = ST_HALT;
            w_instr_nxt   = NOP_WORD;
            w_pc_next_nxt = '0;
            w_valid_nxt   = 1'b0;
          end else begin
            w_pc_nxt      = w_pc_inc;
            w_instr_nxt   = imem_data;
            w_pc_next_nxt = w_pc_inc;
            w_valid_nxt   = 1'b1;
          end
        end
        ST_HALT: begin
          w_instr_nxt   = NOP_WORD;
          w_pc_next_nxt = '0;
          w_valid_nxt   = 1'b0;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign instr_reg   = r_instr;
  assign pc_next_reg = r_pc_next;
  assign valid_reg   = r_valid;
  assign rs          = r_instr[RS_MSB:RS_LSB];
  assign rt          = r_instr[RT_MSB:RT_LSB];
  assign bubble      = branch_taken | w_stall;
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_if_id.sv
// tb/tb_fetch_if_id.sv - self-checking bench for fetch_if_id
module tb_fetch_if_id;

  localparam int          PW    = 7;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          branch_taken;
  logic [PW-1:0] branch_target;
  logic          idex_mem_read;
  logic [4:0]    idex_rt;
  logic [31:0]   instr_reg;
  logic [PW-1:0] pc_next_reg;
  logic          valid_reg;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          bubble;
  logic          halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem [0:127];

  fetch_if_id dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .instr_reg     (instr_reg),
    .pc_next_reg   (pc_next_reg),
    .valid_reg     (valid_reg),
    .rs            (rs),
    .rt            (rt),
    .bubble        (bubble),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  // Reference model: the stage's architectural state, advanced by the rules.
  int          m_pc;
  logic [31:0] m_instr;
  int          m_pcn;
  bit          m_valid;
  bit          m_halted;

  function automatic bit model_stall();
    int src_rs;
    int src_rt;
    src_rs = (m_instr >> 21) & 31;
    src_rt = (m_instr >> 16) & 31;
    return idex_mem_read && (idex_rt != 0) && m_valid &&
           ((idex_rt == src_rs) || (idex_rt == src_rt));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 0; m_instr = 0; m_pcn = 0; m_valid = 0; m_halted = 0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_instr = 0; m_pcn = 0; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      m_instr = 0; m_pcn = 0; m_valid = 0;
    end else if (model_stall()) begin
      // nothing moves
    end else if (imem[m_pc] == HALTW) begin
      m_instr = 0; m_pcn = 0; m_valid = 0; m_halted = 1;
    end else begin
      m_instr = imem[m_pc];
      m_pc    = (m_pc + 1) % 128;
      m_pcn   = m_pc;
      m_valid = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_addr",   32'(imem_addr),   32'(m_pc));
    check("m_instr",  instr_reg,        m_instr);
    check("m_pcn",    32'(pc_next_reg), 32'(m_pcn));
    check("m_valid",  32'(valid_reg),   32'(m_valid));
    check("m_rs",     32'(rs),          (m_instr >> 21) & 31);
    check("m_rt",     32'(rt),          (m_instr >> 16) & 31);
    check("m_bubble", 32'(bubble),      32'(branch_taken || model_stall()));
    check("m_halted", 32'(halted),      32'(m_halted));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'h0100_0000 + 32'(i);
    imem[0]   = 32'h11;
    imem[1]   = 32'h22;
    imem[2]   = 32'h33;
    imem[3]   = 32'h00A0_0000;   // rs = 5
    imem[4]   = 32'h44;
    imem[5]   = 32'h0005_0000;   // rt = 5
    imem[8]   = 32'h88;
    imem[9]   = HALTW;
    imem[127] = 32'h7F7F;

    rst = 1'b0; branch_taken = 0; branch_target = '0; idex_mem_read = 0; idex_rt = '0;
    #2;
    check("rst_addr",   32'(imem_addr), 0);
    check("rst_instr",  instr_reg, 0);
    check("rst_valid",  32'(valid_reg), 0);
    check("rst_halted", 32'(halted), 0);
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch
    step(); check("f1_instr", instr_reg, 32'h11); check("f1_pcn", 32'(pc_next_reg), 1);
    check("f1_valid", 32'(valid_reg), 1);
    step(); check("f2_instr", instr_reg, 32'h22); check("f2_pcn", 32'(pc_next_reg), 2);
    step(); check("f3_instr", instr_reg, 32'h33); check("f3_pcn", 32'(pc_next_reg), 3);
    check("f3_addr", 32'(imem_addr), 3);
    step(); check("f4_instr", instr_reg, 32'h00A0_0000);

    // Load-use on rs
    idex_mem_read = 1; idex_rt = 5'd5; #1;
    check("lu_bubble", 32'(bubble), 1);
    step(); check("lu_hold_addr", 32'(imem_addr), 4); check("lu_hold_instr", instr_reg, 32'h00A0_0000);
    idex_rt = 5'd0; #1;
    check("lu_rt0_bubble", 32'(bubble), 0);
    step(); check("lu_go_instr", instr_reg, 32'h44); check("lu_go_addr", 32'(imem_addr), 5);
    idex_mem_read = 0;

    // Branch while a stall on rt is active
    step(); check("b_pre_instr", instr_reg, 32'h0005_0000);
    idex_mem_read = 1; idex_rt = 5'd5; branch_taken = 1; branch_target = 7'h40; #1;
    check("b_bubble", 32'(bubble), 1);
    step(); check("b_addr", 32'(imem_addr), 32'h40); check("b_instr", instr_reg, 0);
    check("b_valid", 32'(valid_reg), 0);
    idex_mem_read = 0; idex_rt = '0; branch_target = 7'd8;
    step(); check("b8_addr", 32'(imem_addr), 8);
    branch_taken = 0;

    // Halt at PC 9
    step(); check("h_pre_instr", instr_reg, 32'h88); check("h_pre_addr", 32'(imem_addr), 9);
    step(); check("h_halted", 32'(halted), 1); check("h_addr", 32'(imem_addr), 9);
    check("h_valid", 32'(valid_reg), 0); check("h_instr", instr_reg, 0);
    step(); check("h_stay", 32'(halted), 1); check("h_stay_addr", 32'(imem_addr), 9);
    branch_taken = 1; branch_target = 7'h10;
    step(); check("h_exit", 32'(halted), 0); check("h_exit_addr", 32'(imem_addr), 32'h10);

    // PC wrap at 127
    branch_target = 7'd127;
    step(); check("w_addr", 32'(imem_addr), 127);
    branch_taken = 0;
    step(); check("w_instr", instr_reg, 32'h7F7F); check("w_pcn", 32'(pc_next_reg), 0);
    check("w_addr0", 32'(imem_addr), 0);

    // Asynchronous reset during a stall
    branch_taken = 1; branch_target = 7'd3;
    step(); branch_taken = 0;
    step(); check("r_pre_instr", instr_reg, 32'h00A0_0000);
    idex_mem_read = 1; idex_rt = 5'd5; #1;
    check("r_stall", 32'(bubble), 1);
    #1; rst = 1'b0; #1;
    check("r_addr",   32'(imem_addr), 0);
    check("r_instr",  instr_reg, 0);
    check("r_pcn",    32'(pc_next_reg), 0);
    check("r_valid",  32'(valid_reg), 0);
    check("r_halted", 32'(halted), 0);
    check("r_bubble", 32'(bubble), 0);
    @(negedge clk);
    rst = 1'b1; idex_mem_read = 0; idex_rt = '0;
    step(); check("r_after_instr", instr_reg, 32'h11);
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
